// File: rtl/gray_counter_if.sv
// Gray counter bus: control strobes and load value from the master, registered
// code outputs from the counter.
//   en        - count enable, one step per enabled cycle
//   up        - direction (1 = up, 0 = down), used only while en = 1
//   load      - synchronous load strobe
//   load_gray - Gray-coded value captured when load = 1
//   gray      - registered Gray-code count
//   binary    - registered binary equivalent of gray
//   tc        - registered terminal-count flag (wrapped or clamped step)
interface gray_counter_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_gray;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] binary;
    logic             tc;

    modport master (
        output en, up, load, load_gray,
        input  gray, binary, tc
    );

    modport slave (
        input  en, up, load, load_gray,
        output gray, binary, tc
    );
endinterface

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with synchronous load and terminal-count flag.
// One binary count register drives a registered Gray copy; both update on the
// same edge so gray == binary ^ (binary >> 1) holds every cycle.
//   clk - rising-edge clock
//   rst - synchronous active-high reset (beats load, which beats en)
//   bus - gray_counter_if slave: en/up/load/load_gray in, gray/binary/tc out
// WRAP = 1 wraps modulo 2**WIDTH; WRAP = 0 saturates at 0 and all-ones.
// tc pulses for exactly one cycle after a step that wrapped or was clamped.
module gray_counter #(
    parameter int unsigned WIDTH = 4,
    parameter bit          WRAP  = 1'b1
) (
    input logic         clk,
    input logic         rst,
    gray_counter_if.slave bus
);
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] load_bin;
    logic             at_end;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        load_bin            = '0;
        load_bin[WIDTH-1]   = bus.load_gray[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            load_bin[i] = load_bin[i+1] ^ bus.load_gray[i];
        end
    end

    // End value in the requested direction: the step would wrap or clamp.
    assign at_end = bus.up ? (&bin_q) : ~(|bin_q);

    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        if (bus.load) begin
            bin_d = load_bin;
        end else if (bus.en) begin
            tc_d = at_end;
            if (!at_end || WRAP) begin
                bin_d = bus.up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign bus.binary = bin_q;
    assign bus.gray   = gray_q;
    assign bus.tc     = tc_q;
endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;
    logic clk = 1'b0;
    logic rst;
    logic rst8;

    always #5 clk = ~clk;

    gray_counter_if #(.WIDTH(4)) b4 ();
    gray_counter_if #(.WIDTH(4)) bs ();
    gray_counter_if #(.WIDTH(8)) b8 ();

    // The saturating DUT sees exactly the same stimulus as the wrapping one.
    assign bs.en        = b4.en;
    assign bs.up        = b4.up;
    assign bs.load      = b4.load;
    assign bs.load_gray = b4.load_gray;

    gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_wrap (.clk(clk), .rst(rst),  .bus(b4));
    gray_counter #(.WIDTH(4), .WRAP(1'b0)) u_sat  (.clk(clk), .rst(rst),  .bus(bs));
    gray_counter #(.WIDTH(8), .WRAP(1'b1)) u_w8   (.clk(clk), .rst(rst8), .bus(b8));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [3:0] wb, input logic [3:0] wg,
                          input logic wt, input logic [3:0] sb, input logic [3:0] sg,
                          input logic st);
        check({tag, " wrap bin"}, 32'(b4.binary), 32'(wb));
        check({tag, " wrap gray"}, 32'(b4.gray), 32'(wg));
        check({tag, " wrap tc"}, 32'(b4.tc), 32'(wt));
        check({tag, " sat bin"}, 32'(bs.binary), 32'(sb));
        check({tag, " sat gray"}, 32'(bs.gray), 32'(sg));
        check({tag, " sat tc"}, 32'(bs.tc), 32'(st));
    endtask

    // Prefix-XOR form of Gray-to-binary for the reference model.
    function automatic logic [7:0] ref_g2b(input logic [7:0] g);
        logic [7:0] b;
        b = g;
        for (int k = 1; k < 8; k++) b = b ^ (g >> k);
        return b;
    endfunction

    logic [3:0] gray_tab [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                  4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    initial begin
        logic [7:0] m_bin;
        logic       m_tc;
        logic [7:0] old_gray;
        logic       stepping;
        logic [3:0] sb;

        rst = 1'b1;
        rst8 = 1'b1;
        b4.en = 1'b1;
        b4.up = 1'b1;
        b4.load = 1'b1;
        b4.load_gray = 4'hF;
        b8.en = 1'b0;
        b8.up = 1'b0;
        b8.load = 1'b0;
        b8.load_gray = '0;

        // Reset dominates both load and en.
        tick();
        tick();
        check4("reset", 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

        // Full up-count cycle; saturating copy clamps on the 16th step.
        rst = 1'b0;
        b4.load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            sb = (i < 15) ? 4'(i + 1) : 4'hF;
            check4($sformatf("up%0d", i), 4'(i + 1), gray_tab[i], i == 15,
                   sb, sb ^ (sb >> 1), i == 15);
        end

        // Load 1011 then step down.
        b4.en = 1'b0;
        b4.load = 1'b1;
        b4.load_gray = 4'hB;
        tick();
        check4("load1011", 4'hD, 4'hB, 1'b0, 4'hD, 4'hB, 1'b0);
        b4.load = 1'b0;
        b4.en = 1'b1;
        b4.up = 1'b0;
        tick();
        check4("down", 4'hC, 4'hA, 1'b0, 4'hC, 4'hA, 1'b0);

        // Down from zero: wrap vs clamp, repeated clamp keeps tc high.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check4("under1", 4'hF, 4'h8, 1'b1, 4'h0, 4'h0, 1'b1);
        tick();
        check4("under2", 4'hE, 4'h9, 1'b0, 4'h0, 4'h0, 1'b1);
        b4.en = 1'b0;
        tick();
        check4("idle", 4'hE, 4'h9, 1'b0, 4'h0, 4'h0, 1'b0);

        // Load beats en; reset then discards the next step.
        b4.load = 1'b1;
        b4.en = 1'b1;
        b4.up = 1'b1;
        b4.load_gray = 4'h6;
        tick();
        check4("loaden", 4'h4, 4'h6, 1'b0, 4'h4, 4'h6, 1'b0);
        b4.load = 1'b0;
        rst = 1'b1;
        tick();
        check4("rsten", 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

        // Direction reversal with no bubble; first step after reset starts at 0.
        rst = 1'b0;
        tick();
        check4("dir1", 4'h1, 4'h1, 1'b0, 4'h1, 4'h1, 1'b0);
        tick();
        check4("dir2", 4'h2, 4'h3, 1'b0, 4'h2, 4'h3, 1'b0);
        b4.up = 1'b0;
        tick();
        check4("dir3", 4'h1, 4'h1, 1'b0, 4'h1, 4'h1, 1'b0);
        b4.en = 1'b0;

        // 8-bit randomized run against a reference model.
        tick();
        rst8 = 1'b0;
        m_bin = '0;
        for (int c = 0; c < 2000; c++) begin
            rst8 = ($urandom_range(0, 49) == 0);
            b8.load = ($urandom_range(0, 9) == 0);
            b8.en = ($urandom_range(0, 3) != 0);
            b8.up = $urandom_range(0, 1) == 1;
            b8.load_gray = 8'($urandom);
            old_gray = b8.gray;
            stepping = b8.en && !b8.load && !rst8;
            if (rst8) begin
                m_bin = '0;
                m_tc = 1'b0;
            end else if (b8.load) begin
                m_bin = ref_g2b(b8.load_gray);
                m_tc = 1'b0;
            end else if (b8.en) begin
                m_tc = b8.up ? (m_bin == 8'hFF) : (m_bin == 8'h00);
                m_bin = b8.up ? m_bin + 8'd1 : m_bin - 8'd1;
            end else begin
                m_tc = 1'b0;
            end
            tick();
            check("r8 bin", 32'(b8.binary), 32'(m_bin));
            check("r8 inv", 32'(b8.gray), 32'(b8.binary ^ (b8.binary >> 1)));
            check("r8 tc", 32'(b8.tc), 32'(m_tc));
            if (stepping) check("r8 onebit", $countones(b8.gray ^ old_gray), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001: Parameter WIDTH, default 4, sets the count/code width in bits (legal 2..32).
REQ-002: Parameter WRAP, default 1: 1 means modulo wrap-around, 0 means saturate at the end values.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: en  input  1  count enable; one step per enabled cycle.
REQ-006: up  input  1  direction: 1 counts up, 0 counts down; sampled only when en=1.
REQ-007: load  input  1  synchronous load strobe.
REQ-008: load_gray  input  WIDTH  Gray-coded value to load when load=1.
REQ-009: gray  output  WIDTH  registered Gray-code count.
REQ-010: binary  output  WIDTH  registered binary equivalent of gray.
REQ-011: tc  output  1  registered terminal-count flag.

Function
REQ-012: The block SHALL hold one internal binary count register; gray and binary SHALL both be registers updated on the same edge, with no combinational path from any input to any output.
REQ-013: At every edge the invariant gray == binary ^ (binary >> 1) SHALL hold.
REQ-014: The per-edge priority SHALL be rst > load > en; with none asserted, all outputs hold.
REQ-015: On load: binary <= Gray-to-binary of load_gray (b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]); gray <= load_gray; tc <= 0; visible 1 cycle after the strobe edge.
REQ-016: On en=1, up=1: binary <= binary+1, truncated to WIDTH bits.
REQ-017: On en=1, up=0: binary <= binary-1, truncated to WIDTH bits.
REQ-018: Wrap-around, WRAP=1: all-ones + 1 -> 0 and 0 - 1 -> all-ones.
REQ-019: Saturation, WRAP=0: an up step at all-ones and a down step at 0 SHALL leave binary/gray unchanged.
REQ-020: tc SHALL be 1 for exactly the cycle following an enabled step that wrapped (WRAP=1) or was clamped (WRAP=0), and 0 in every other cycle.
REQ-021: Consecutive clamped steps under WRAP=0 SHALL keep tc high for each such cycle.
REQ-022: Every enabled, non-clamped step SHALL change exactly one bit of gray.
REQ-023: A direction change between consecutive enabled cycles SHALL take effect on the next step with no bubble.
REQ-024: Latency from an en/load edge to the updated outputs SHALL be exactly 1 clock.

Reset
REQ-025: With rst=1 at a rising edge: binary=0, gray=0, tc=0 on the next cycle, regardless of en or load.
REQ-026: Reset asserted mid-count or together with load SHALL discard the pending step/load.
REQ-027: The first step after rst deasserts SHALL start from 0.

Verification
REQ-028: Reset: rst=1 for 2 cycles with en=1, load=1 -> gray=0000, binary=0000, tc=0.
REQ-029: WIDTH=4, WRAP=1, en=1, up=1 for 16 cycles -> gray 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; binary 1..15,0; tc=1 only after the 16th step.
REQ-030: load_gray=1011 -> binary=1101, gray=1011; then en=1, up=0 -> binary=1100, gray=1010, tc=0.
REQ-031: From 0, en=1, up=0: WRAP=1 -> binary=1111, gray=1000, tc=1; WRAP=0 -> binary=0000, gray=0000, tc=1 each clamped cycle.
REQ-032: load=1 and en=1 together, load_gray=0110 -> binary=0100, gray=0110 (no step); next cycle rst=1 with en=1 -> all outputs 0.
REQ-033: WIDTH=8, random en/up/load for 2000 cycles -> invariant REQ-013 holds, single-bit Gray change per step, binary matches a reference model every cycle.
